// File: rtl/shreg_seq_if.sv
// Command/data bus of the sequential shift unit: operand load, shift command
// and the status returned to the control unit.
interface shreg_seq_if #(
  parameter int N  = 4,
  parameter int SW = 2
);
  logic          en;
  logic          load;
  logic [N-1:0]  data;
  logic          start;
  logic [2:0]    mode;
  logic [SW-1:0] amt;
  logic [N-1:0]  sr_out;
  logic          busy;
  logic          done;
  logic          cout;
  logic          ovf;

  modport master (
    output en, load, data, start, mode, amt,
    input  sr_out, busy, done, cout, ovf
  );

  modport slave (
    input  en, load, data, start, mode, amt,
    output sr_out, busy, done, cout, ovf
  );
endinterface

// File: rtl/shreg_seq.sv
// Parametrised sequential shift unit: N-bit operand, six shift modes, one
// position per enabled clock, with busy/done handshake, carry-out and overflow.
module shreg_seq #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input logic        clk,
  input logic        rst,
  shreg_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_LSL = 3'b000,
    M_ASL = 3'b001,
    M_LSR = 3'b010,
    M_ASR = 3'b011,
    M_ROL = 3'b100,
    M_ROR = 3'b101
  } mode_t;

  state_t        state_q;
  logic [2:0]    mode_q;
  logic [SW-1:0] cnt_q;
  logic [N-1:0]  sr_q;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;
  logic          ovf_q;

  logic [N-1:0]  step_sr;
  logic          step_c;
  logic          step_v;
  logic          accept;

  // One-position step of the latched mode applied to the current contents.
  always_comb begin
    step_sr = sr_q;
    step_c  = 1'b0;
    step_v  = 1'b0;
    case (mode_q)
      M_LSL: begin
        step_sr = {sr_q[N-2:0], 1'b0};
        step_c  = sr_q[N-1];
        step_v  = sr_q[N-1];
      end
      M_ASL: begin
        step_sr = {sr_q[N-1], sr_q[N-3:0], 1'b0};
        step_c  = sr_q[N-2];
        step_v  = sr_q[N-2] ^ sr_q[N-1];
      end
      M_LSR: begin
        step_sr = {1'b0, sr_q[N-1:1]};
        step_c  = sr_q[0];
      end
      M_ASR: begin
        step_sr = {sr_q[N-1], sr_q[N-1:1]};
        step_c  = sr_q[0];
      end
      M_ROL: begin
        step_sr = {sr_q[N-2:0], sr_q[N-1]};
        step_c  = sr_q[N-1];
      end
      M_ROR: begin
        step_sr = {sr_q[0], sr_q[N-1:1]};
        step_c  = sr_q[0];
      end
      default: begin
        step_sr = sr_q;
        step_c  = 1'b0;
        step_v  = 1'b0;
      end
    endcase
  end

  assign accept = bus.start && (state_q != ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.en) begin
      if (bus.load) begin
        sr_q    <= bus.data;
        ovf_q   <= 1'b0;
        cout_q  <= 1'b0;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sr_q   <= step_sr;
            cout_q <= step_c;
            ovf_q  <= ovf_q | step_v;
            cnt_q  <= cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            // IDLE and DONE both accept a new command; DONE falls back to IDLE otherwise.
            if (accept) begin
              mode_q <= bus.mode;
              cnt_q  <= bus.amt;
              ovf_q  <= 1'b0;
              cout_q <= 1'b0;
              if (bus.amt != '0) begin
                state_q <= ST_SHIFT;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.sr_out = sr_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq (N=4, SW=2): vector table through a result scoreboard,
// then hand-written multi-cycle sequences for reset, stall, abort and chaining.
module tb_shreg_seq;

  logic clk;
  logic rst;

  shreg_seq_if #(.N(4), .SW(2)) bus ();

  shreg_seq #(.N(4), .SW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] mode;
    logic [1:0] amt;
    logic [3:0] sr;
    logic       c;
    logic       v;
  } vec_t;

  typedef struct {
    logic [3:0] sr;
    logic       c;
    logic       v;
    logic [1:0] amt;
  } exp_t;

  vec_t tbl [14];
  exp_t exp_q [$];
  int   ncmp;
  int   nerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned busy_n;
    bit          seen;
    exp_t        e;
    cyc();
    bus.load  = 1'b1;
    bus.data  = v.data;
    bus.start = 1'b0;
    cyc();
    bus.load  = 1'b0;
    bus.start = 1'b1;
    bus.mode  = v.mode;
    bus.amt   = v.amt;
    exp_q.push_back('{sr: v.sr, c: v.c, v: v.v, amt: v.amt});
    cyc();
    bus.start = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        chk($sformatf("vec%0d sr", idx), bus.sr_out, e.sr);
        chk($sformatf("vec%0d cout", idx), bus.cout, e.c);
        chk($sformatf("vec%0d ovf", idx), bus.ovf, e.v);
        chk($sformatf("vec%0d busy_cycles", idx), busy_n, e.amt);
        chk($sformatf("vec%0d busy_at_done", idx), bus.busy, 0);
      end else begin
        cyc();
      end
    end
    if (!seen) begin
      chk($sformatf("vec%0d done_timeout", idx), 0, 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      cyc();
      chk($sformatf("vec%0d done_one_cycle", idx), bus.done, 0);
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    tbl[0]  = '{4'b0011, 3'b000, 2'd2, 4'b1100, 1'b0, 1'b0};
    tbl[1]  = '{4'b1001, 3'b000, 2'd1, 4'b0010, 1'b1, 1'b1};
    tbl[2]  = '{4'b1011, 3'b001, 2'd1, 4'b1110, 1'b0, 1'b1};
    tbl[3]  = '{4'b0011, 3'b001, 2'd2, 4'b0100, 1'b1, 1'b1};
    tbl[4]  = '{4'b1101, 3'b010, 2'd3, 4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{4'b1000, 3'b011, 2'd3, 4'b1111, 1'b0, 1'b0};
    tbl[6]  = '{4'b1001, 3'b100, 2'd1, 4'b0011, 1'b1, 1'b0};
    tbl[7]  = '{4'b0110, 3'b101, 2'd3, 4'b1100, 1'b1, 1'b0};
    tbl[8]  = '{4'b1010, 3'b110, 2'd3, 4'b1010, 1'b0, 1'b0};
    tbl[9]  = '{4'b0101, 3'b111, 2'd1, 4'b0101, 1'b0, 1'b0};
    tbl[10] = '{4'b1111, 3'b000, 2'd0, 4'b1111, 1'b0, 1'b0};
    tbl[11] = '{4'b0001, 3'b010, 2'd1, 4'b0000, 1'b1, 1'b0};
    tbl[12] = '{4'b0111, 3'b011, 2'd2, 4'b0001, 1'b1, 1'b0};
    tbl[13] = '{4'b1000, 3'b100, 2'd3, 4'b0100, 1'b0, 1'b0};

    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.load  = 1'b0;
    bus.data  = '0;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.amt   = '0;
    cyc();
    cyc();
    chk("rst sr", bus.sr_out, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst cout", bus.cout, 0);
    chk("rst ovf", bus.ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // ASR multi-step with per-cycle trace
    cyc(); bus.load = 1'b1; bus.data = 4'b1000;
    cyc(); bus.load = 1'b0; bus.start = 1'b1; bus.mode = 3'b011; bus.amt = 2'd3;
    cyc(); bus.start = 1'b0;
    chk("asr t0 busy", bus.busy, 1);
    cyc(); chk("asr s1", bus.sr_out, 4'b1100); chk("asr s1 busy", bus.busy, 1);
    cyc(); chk("asr s2", bus.sr_out, 4'b1110); chk("asr s2 busy", bus.busy, 1);
    cyc(); chk("asr s3", bus.sr_out, 4'b1111); chk("asr done", bus.done, 1);
    chk("asr ovf", bus.ovf, 0); chk("asr cout", bus.cout, 0);

    // Stall with en low for two cycles after the first shift
    cyc(); bus.load = 1'b1; bus.data = 4'b0011;
    cyc(); bus.load = 1'b0; bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 2'd3;
    cyc(); bus.start = 1'b0;
    cyc(); chk("stall s1", bus.sr_out, 4'b0110); bus.en = 1'b0;
    cyc(); chk("stall hold1", bus.sr_out, 4'b0110); chk("stall hold1 busy", bus.busy, 1);
    cyc(); chk("stall hold2", bus.sr_out, 4'b0110); bus.en = 1'b1;
    cyc(); chk("stall s2", bus.sr_out, 4'b1100); chk("stall s2 done", bus.done, 0);
    cyc(); chk("stall s3", bus.sr_out, 4'b1001); chk("stall done", bus.done, 1);
    chk("stall cout", bus.cout, 1);
    bus.en = 1'b0;
    cyc(); chk("stall done held", bus.done, 1); bus.en = 1'b1;
    cyc(); chk("stall done clears", bus.done, 0);

    // Abort by load, then zero-amount start
    cyc(); bus.load = 1'b1; bus.data = 4'b1100;
    cyc(); bus.load = 1'b0; bus.start = 1'b1; bus.mode = 3'b010; bus.amt = 2'd3;
    cyc(); bus.start = 1'b0;
    cyc(); chk("abort s1", bus.sr_out, 4'b0110);
    bus.load = 1'b1; bus.data = 4'b0101;
    cyc(); bus.load = 1'b0;
    chk("abort sr", bus.sr_out, 4'b0101); chk("abort busy", bus.busy, 0);
    chk("abort no done", bus.done, 0);
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 2'd0;
    cyc(); bus.start = 1'b0;
    chk("amt0 done", bus.done, 1); chk("amt0 busy", bus.busy, 0);
    chk("amt0 sr", bus.sr_out, 4'b0101);
    cyc(); chk("amt0 done clears", bus.done, 0); chk("amt0 busy after", bus.busy, 0);

    // load and start on the same edge: load wins
    bus.load = 1'b1; bus.data = 4'b1010; bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 2'd1;
    cyc(); bus.load = 1'b0; bus.start = 1'b0;
    chk("ld+st sr", bus.sr_out, 4'b1010); chk("ld+st busy", bus.busy, 0);
    cyc(); chk("ld+st sr hold", bus.sr_out, 4'b1010); chk("ld+st no done", bus.done, 0);

    // Back-to-back: ROR amt 2 then LSL amt 1 issued during DONE
    cyc(); bus.load = 1'b1; bus.data = 4'b0001;
    cyc(); bus.load = 1'b0; bus.start = 1'b1; bus.mode = 3'b101; bus.amt = 2'd2;
    cyc(); bus.start = 1'b0;
    cyc(); chk("b2b s1", bus.sr_out, 4'b1000);
    cyc(); chk("b2b first done", bus.done, 1); chk("b2b s2", bus.sr_out, 4'b0100);
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 2'd1;
    cyc(); bus.start = 1'b0;
    chk("b2b no gap busy", bus.busy, 1); chk("b2b gap done", bus.done, 0);
    cyc(); chk("b2b second done", bus.done, 1); chk("b2b s3", bus.sr_out, 4'b1000);
    chk("b2b cout", bus.cout, 0); chk("b2b ovf", bus.ovf, 0);

    // Asynchronous reset mid-shift
    cyc(); bus.load = 1'b1; bus.data = 4'b0110;
    cyc(); bus.load = 1'b0; bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 2'd3;
    cyc(); bus.start = 1'b0;
    cyc(); chk("rstmid s1", bus.sr_out, 4'b1100);
    #2 rst = 1'b1;
    #1;
    chk("rstmid sr", bus.sr_out, 0); chk("rstmid busy", bus.busy, 0);
    chk("rstmid done", bus.done, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk($sformatf("rstmid no done %0d", i), bus.done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
